buyruk_onbellegi: RTL and testbench

Direct-mapped, read-only instruction cache that answers fetch-stage instruction requests. Fetch presents a program counter with a valid/ready handshake and receives the 32-bit instruction word tagged with its PC. On a hit, the response arrives one cycle after the request. On a miss, a fixed-length line refill is run over a simple word-serial main-memory read interface. A flush input supports `fence.i`, and a cancel input lets fetch discard an in-flight response after a branch redirect.

---
 rtl/buyruk_onbellegi.sv | 219 +++++++++++++++++++++
 tb/tb_buyruk_onbellegi.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buyruk_onbellegi.sv
// buyruk_onbellegi: direct-mapped, read-only instruction cache for the fetch stage.
// A hit answers one cycle after the request is accepted. A miss refills the whole
// line word by word over a simple main-memory read interface, then answers.
// Ports:
//   clk_i, rst_i           clock, synchronous active-low reset
//   getir_istek_i/_ps_i    fetch request valid and PC
//   getir_hazir_o          request can be accepted this cycle
//   getir_iptal_i          drop the pending / in-flight response
//   getir_gecerli_o        response valid, with getir_deger_o (word) and getir_ps_o (PC)
//   temizle_i              invalidate every line (fence.i)
//   ana_bellek_*           word-serial refill read: request, address, data valid, data
module buyruk_onbellegi #(
   parameter int SATIR_SAYISI  = 64,
   parameter int KELIME_SAYISI = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        getir_istek_i,
   input  logic [31:0] getir_ps_i,
   output logic        getir_hazir_o,
   input  logic        getir_iptal_i,
   output logic        getir_gecerli_o,
   output logic [31:0] getir_deger_o,
   output logic [31:0] getir_ps_o,
   input  logic        temizle_i,
   output logic        ana_bellek_istek_o,
   output logic [31:0] ana_bellek_adres_o,
   input  logic        ana_bellek_gecerli_i,
   input  logic [31:0] ana_bellek_veri_i
);

   localparam int O  = $clog2(KELIME_SAYISI);
   localparam int I  = $clog2(SATIR_SAYISI);
   localparam int TW = 32 - O - I - 2;

   localparam logic [1:0] BOSTA       = 2'd0;
   localparam logic [1:0] KARSILASTIR = 2'd1;
   localparam logic [1:0] DOLDUR      = 2'd2;
   localparam logic [1:0] YANITLA     = 2'd3;

   logic [1:0]              r_durum;
   logic [31:0]             r_ps;
   logic [SATIR_SAYISI-1:0] r_gecerli_bit;
   logic [TW-1:0]           r_etiket [SATIR_SAYISI];
   logic [31:0]             r_veri   [SATIR_SAYISI*KELIME_SAYISI];
   logic [31:0]             r_tampon [KELIME_SAYISI];
   logic [O-1:0]            r_vurus;
   logic                    r_iptal_bekle;
   logic                    r_temizle_bekle;
   logic                    r_istek;
   logic [31:0]             r_adres;
   logic [31:0]             r_son_deger;
   logic [31:0]             r_son_ps;

   logic [I-1:0]  w_indeks;
   logic [O-1:0]  w_ofset;
   logic [TW-1:0] w_etiket;
   logic          w_isabet;
   logic          w_son_vurus;
   logic          w_bellek_al;
   logic          w_gecerli_ham;
   logic          w_hazir_ham;
   logic          w_gecerli;
   logic          w_hazir;
   logic          w_kabul;
   logic [31:0]   w_kelime;

   assign w_indeks    = r_ps[O+I+1:O+2];
   assign w_ofset     = r_ps[O+1:2];
   assign w_etiket    = r_ps[31:O+I+2];
   assign w_isabet    = r_gecerli_bit[w_indeks] && (r_etiket[w_indeks] == w_etiket);
   assign w_son_vurus = (r_vurus == {O{1'b1}});
   // Memory data counts only while a refill beat is actually being requested.
   assign w_bellek_al = (r_durum == DOLDUR) && r_istek && ana_bellek_gecerli_i;

   // Response / ready decode; cancel suppresses the response in the same cycle.
   always_comb begin
      w_gecerli_ham = 1'b0;
      w_hazir_ham   = 1'b0;
      w_kelime      = r_veri[{w_indeks, w_ofset}];
      case (r_durum)
         BOSTA: begin
            w_hazir_ham = 1'b1;
         end
         KARSILASTIR: begin
            w_gecerli_ham = w_isabet & ~getir_iptal_i;
            // A cancelled miss frees the cache, so a new request may enter.
            w_hazir_ham   = w_isabet | getir_iptal_i;
         end
         DOLDUR: begin
            w_hazir_ham = 1'b0;
         end
         YANITLA: begin
            w_gecerli_ham = ~getir_iptal_i;
            w_kelime      = r_tampon[w_ofset];
         end
         default: begin
            w_hazir_ham = 1'b0;
         end
      endcase
   end

   assign w_gecerli = rst_i & w_gecerli_ham;
   assign w_hazir   = rst_i & w_hazir_ham;
   assign w_kabul   = w_hazir & getir_istek_i;

   // Control state, valid bits, refill sequencing and held response values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_durum         <= BOSTA;
         r_ps            <= 32'd0;
         r_gecerli_bit   <= {SATIR_SAYISI{1'b0}};
         r_vurus         <= {O{1'b0}};
         r_iptal_bekle   <= 1'b0;
         r_temizle_bekle <= 1'b0;
         r_istek         <= 1'b0;
         r_adres         <= 32'd0;
         r_son_deger     <= 32'd0;
         r_son_ps        <= 32'd0;
      end else begin
         if (w_gecerli) begin
            r_son_deger <= w_kelime;
            r_son_ps    <= r_ps;
         end
         if (w_kabul) begin
            r_ps <= getir_ps_i;
         end
         case (r_durum)
            BOSTA: begin
               if (w_kabul) begin
                  r_durum <= KARSILASTIR;
               end
               if (temizle_i) begin
                  r_gecerli_bit <= {SATIR_SAYISI{1'b0}};
               end
            end
            KARSILASTIR: begin
               if (w_kabul) begin
                  r_durum <= KARSILASTIR;
               end else if (w_isabet || getir_iptal_i) begin
                  r_durum <= BOSTA;
               end else begin
                  r_durum       <= DOLDUR;
                  r_istek       <= 1'b1;
                  r_adres       <= {r_ps[31:O+2], {O{1'b0}}, 2'b00};
                  r_vurus       <= {O{1'b0}};
                  r_iptal_bekle <= 1'b0;
               end
               // The lookup above used the pre-flush valid bits.
               if (temizle_i) begin
                  r_gecerli_bit <= {SATIR_SAYISI{1'b0}};
               end
            end
            DOLDUR: begin
               if (getir_iptal_i) begin
                  r_iptal_bekle <= 1'b1;
               end
               if (temizle_i) begin
                  r_temizle_bekle <= 1'b1;
               end
               if (w_bellek_al) begin
                  r_vurus <= r_vurus + O'(1);
                  if (w_son_vurus) begin
                     r_istek                 <= 1'b0;
                     r_gecerli_bit[w_indeks] <= 1'b1;
                     if (r_iptal_bekle || getir_iptal_i) begin
                        r_durum         <= BOSTA;
                        r_temizle_bekle <= 1'b0;
                        // Later assignment wins: a pending flush also drops the new line.
                        if (r_temizle_bekle || temizle_i) begin
                           r_gecerli_bit <= {SATIR_SAYISI{1'b0}};
                        end
                     end else begin
                        r_durum <= YANITLA;
                     end
                  end else begin
                     r_adres <= r_adres + 32'd4;
                  end
               end
            end
            YANITLA: begin
               r_durum         <= BOSTA;
               r_temizle_bekle <= 1'b0;
               if (r_temizle_bekle || temizle_i) begin
                  r_gecerli_bit <= {SATIR_SAYISI{1'b0}};
               end
            end
            default: begin
               r_durum <= BOSTA;
            end
         endcase
      end
   end

   // Refill buffer capture and line write on the final beat (data needs no reset).
   always_ff @(posedge clk_i) begin
      if (rst_i && w_bellek_al) begin
         r_tampon[r_vurus] <= ana_bellek_veri_i;
         if (w_son_vurus) begin
            r_etiket[w_indeks] <= w_etiket;
            for (int k = 0; k < KELIME_SAYISI; k++) begin
               if (k == KELIME_SAYISI - 1) begin
                  r_veri[{w_indeks, O'(k)}] <= ana_bellek_veri_i;
               end else begin
                  r_veri[{w_indeks, O'(k)}] <= r_tampon[k];
               end
            end
         end
      end
   end

   assign getir_hazir_o      = w_hazir;
   assign getir_gecerli_o    = w_gecerli;
   assign getir_deger_o      = w_gecerli ? w_kelime : r_son_deger;
   assign getir_ps_o         = w_gecerli ? r_ps : r_son_ps;
   assign ana_bellek_istek_o = r_istek;
   assign ana_bellek_adres_o = r_adres;

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Testbench for buyruk_onbellegi: directed scenarios plus randomized fetches
// checked against a line-level valid/tag model and a deterministic memory image.
module tb_buyruk_onbellegi;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        getir_istek_i;
   logic [31:0] getir_ps_i;
   logic        getir_hazir_o;
   logic        getir_iptal_i;
   logic        getir_gecerli_o;
   logic [31:0] getir_deger_o;
   logic [31:0] getir_ps_o;
   logic        temizle_i;
   logic        ana_bellek_istek_o;
   logic [31:0] ana_bellek_adres_o;
   logic        ana_bellek_gecerli_i;
   logic [31:0] ana_bellek_veri_i;

   int          checks = 0;
   int          errors = 0;
   int          wait_n = 0;
   int          wait_cnt = 0;
   logic [31:0] q_adres [$];
   bit          mdl_gecerli [64];
   logic [21:0] mdl_etiket  [64];

   buyruk_onbellegi dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .getir_istek_i(getir_istek_i), .getir_ps_i(getir_ps_i),
      .getir_hazir_o(getir_hazir_o), .getir_iptal_i(getir_iptal_i),
      .getir_gecerli_o(getir_gecerli_o), .getir_deger_o(getir_deger_o),
      .getir_ps_o(getir_ps_o), .temizle_i(temizle_i),
      .ana_bellek_istek_o(ana_bellek_istek_o), .ana_bellek_adres_o(ana_bellek_adres_o),
      .ana_bellek_gecerli_i(ana_bellek_gecerli_i), .ana_bellek_veri_i(ana_bellek_veri_i)
   );

   always #5 clk_i = ~clk_i;

   // Memory image: 0x100..0x10C hold 0x11..0x44, everything else is an address hash.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a >= 32'h100 && a <= 32'h10C) return ({30'd0, a[3:2]} + 32'd1) * 32'h11;
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
   endfunction

   function automatic bit mdl_hit(input logic [31:0] pc);
      return mdl_gecerli[pc[9:4]] && (mdl_etiket[pc[9:4]] == pc[31:10]);
   endfunction

   // Hit: one cycle. Miss: one compare cycle, four beats of (wait+1) cycles, then response.
   function automatic int mdl_lat(input logic [31:0] pc);
      return mdl_hit(pc) ? 1 : 2 + 4 * (wait_n + 1);
   endfunction

   function automatic void mdl_fill(input logic [31:0] pc);
      mdl_gecerli[pc[9:4]] = 1'b1;
      mdl_etiket[pc[9:4]]  = pc[31:10];
   endfunction

   function automatic void mdl_flush();
      for (int i = 0; i < 64; i++) mdl_gecerli[i] = 1'b0;
   endfunction

   // Main-memory responder: grants each requested word after wait_n idle cycles.
   always @(negedge clk_i) begin
      if (ana_bellek_istek_o !== 1'b1) begin
         ana_bellek_gecerli_i = 1'b0;
         wait_cnt = 0;
      end else if (wait_cnt >= wait_n) begin
         ana_bellek_gecerli_i = 1'b1;
         ana_bellek_veri_i    = mem_word(ana_bellek_adres_o);
         q_adres.push_back(ana_bellek_adres_o);
         wait_cnt = 0;
      end else begin
         ana_bellek_gecerli_i = 1'b0;
         wait_cnt++;
      end
   end

   // Issue one fetch; report the response cycle (or the cycle ready returned if none).
   task automatic fetch(input logic [31:0] pc, input int flush_k, input int cancel_k,
                        output int lat, output logic [31:0] deger, output logic [31:0] ps_out,
                        output bit seen);
      seen = 1'b0; lat = -1; deger = 32'd0; ps_out = 32'd0;
      @(posedge clk_i); #1;
      getir_istek_i = 1'b1; getir_ps_i = pc;
      @(posedge clk_i); #1;
      getir_istek_i = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         if (k > 1) begin @(posedge clk_i); #1; end
         temizle_i     = (k == flush_k);
         getir_iptal_i = (k == cancel_k);
         @(negedge clk_i);
         if (getir_gecerli_o === 1'b1) begin
            seen = 1'b1; lat = k; deger = getir_deger_o; ps_out = getir_ps_o;
            break;
         end
         if (getir_hazir_o === 1'b1) begin
            lat = k;
            break;
         end
      end
      temizle_i = 1'b0; getir_iptal_i = 1'b0;
      if (lat < 0) begin
         checks++; errors++;
         $display("FAIL fetch_timeout pc %h no response or ready within bound", pc);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0; getir_istek_i = 1'b0; getir_ps_i = 32'd0;
      getir_iptal_i = 1'b0; temizle_i = 1'b0;
      ana_bellek_gecerli_i = 1'b0; ana_bellek_veri_i = 32'd0;
      mdl_flush();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checks++; if (getir_hazir_o !== 1'b0) begin errors++; $display("FAIL reset_hazir got %b want 0", getir_hazir_o); end
      checks++; if (getir_gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_gecerli got %b want 0", getir_gecerli_o); end
      checks++; if (getir_deger_o !== 32'd0) begin errors++; $display("FAIL reset_deger got %h want 0", getir_deger_o); end
      checks++; if (getir_ps_o !== 32'd0) begin errors++; $display("FAIL reset_ps got %h want 0", getir_ps_o); end
      checks++; if (ana_bellek_istek_o !== 1'b0) begin errors++; $display("FAIL reset_istek got %b want 0", ana_bellek_istek_o); end
      checks++; if (ana_bellek_adres_o !== 32'd0) begin errors++; $display("FAIL reset_adres got %h want 0", ana_bellek_adres_o); end
      @(posedge clk_i); #1; rst_i = 1'b1;
      @(negedge clk_i);
      checks++; if (getir_hazir_o !== 1'b1) begin errors++; $display("FAIL reset_release_hazir got %b want 1", getir_hazir_o); end
   endtask

   task automatic test_cold_miss();
      int lat; logic [31:0] d, p; bit seen;
      q_adres.delete();
      fetch(32'h104, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != 6) begin errors++; $display("FAIL cold_lat got seen %0d lat %0d want lat 6", seen, lat); end
      checks++; if (d !== 32'h22 || p !== 32'h104) begin errors++; $display("FAIL cold_data got %h/%h want 00000022/00000104", d, p); end
      checks++; if (q_adres.size() != 4) begin errors++; $display("FAIL cold_beats got %0d want 4", q_adres.size()); end
      else for (int j = 0; j < 4; j++) begin
         checks++;
         if (q_adres[j] !== 32'h100 + 32'(4 * j)) begin errors++; $display("FAIL cold_addr%0d got %h want %h", j, q_adres[j], 32'h100 + 32'(4 * j)); end
      end
      mdl_fill(32'h104);
      fetch(32'h108, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != 1 || d !== 32'h33) begin errors++; $display("FAIL cold_rehit got lat %0d data %h want lat 1 data 00000033", lat, d); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc;
      for (int i = 0; i <= 4; i++) begin
         @(posedge clk_i); #1;
         getir_istek_i = (i < 4);
         getir_ps_i    = 32'h100 + 32'(4 * i);
         @(negedge clk_i);
         checks++; if (getir_hazir_o !== 1'b1) begin errors++; $display("FAIL b2b_hazir%0d got %b want 1", i, getir_hazir_o); end
         if (i > 0) begin
            pc = 32'h100 + 32'(4 * (i - 1));
            checks++;
            if (getir_gecerli_o !== 1'b1 || getir_ps_o !== pc || getir_deger_o !== mem_word(pc)) begin
               errors++;
               $display("FAIL b2b_resp%0d got v%b %h/%h want v1 %h/%h", i, getir_gecerli_o, getir_ps_o, getir_deger_o, pc, mem_word(pc));
            end
         end
      end
      getir_istek_i = 1'b0;
   endtask

   task automatic test_conflict();
      int lat, exp; logic [31:0] d, p; bit seen;
      q_adres.delete();
      exp = mdl_lat(32'h500);
      fetch(32'h500, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != exp || d !== mem_word(32'h500)) begin errors++; $display("FAIL conflict_fill got lat %0d data %h want lat %0d data %h", lat, d, exp, mem_word(32'h500)); end
      checks++; if (q_adres.size() != 4 || q_adres[0] !== 32'h500 || q_adres[3] !== 32'h50C) begin errors++; $display("FAIL conflict_addr got %0d beats first %h", q_adres.size(), q_adres[0]); end
      mdl_fill(32'h500);
      exp = mdl_lat(32'h100);
      fetch(32'h100, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != exp || d !== 32'h11) begin errors++; $display("FAIL conflict_remiss got lat %0d data %h want lat %0d data 00000011", lat, d, exp); end
      mdl_fill(32'h100);
   endtask

   task automatic test_cancel_refill();
      int lat; logic [31:0] d, p; bit seen;
      wait_n = 2;
      fetch(32'h200, 0, 6, lat, d, p, seen);
      checks++; if (seen) begin errors++; $display("FAIL cancel_resp got valid pulse want none"); end
      checks++; if (lat != 14) begin errors++; $display("FAIL cancel_ready got cycle %0d want 14", lat); end
      mdl_fill(32'h200);
      fetch(32'h200, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != 1 || d !== mem_word(32'h200)) begin errors++; $display("FAIL cancel_rehit got lat %0d data %h want lat 1 data %h", lat, d, mem_word(32'h200)); end
      wait_n = 0;
   endtask

   task automatic test_flush();
      int lat, exp; logic [31:0] d, p; bit seen;
      exp = mdl_lat(32'h100);
      fetch(32'h100, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != exp) begin errors++; $display("FAIL flush_prehit got lat %0d want %0d", lat, exp); end
      @(posedge clk_i); #1; temizle_i = 1'b1;
      @(posedge clk_i); #1; temizle_i = 1'b0;
      mdl_flush();
      exp = mdl_lat(32'h100);
      fetch(32'h100, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != exp || d !== 32'h11) begin errors++; $display("FAIL flush_miss got lat %0d data %h want lat %0d data 00000011", lat, d, exp); end
      mdl_fill(32'h100);
      exp = mdl_lat(32'h300);
      fetch(32'h300, 3, 0, lat, d, p, seen);
      checks++; if (!seen || lat != exp || d !== mem_word(32'h300) || p !== 32'h300) begin errors++; $display("FAIL flush_midfill got lat %0d data %h want lat %0d data %h", lat, d, exp, mem_word(32'h300)); end
      mdl_fill(32'h300);
      mdl_flush();
      exp = mdl_lat(32'h300);
      fetch(32'h300, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != exp) begin errors++; $display("FAIL flush_after got lat %0d want %0d", lat, exp); end
      mdl_fill(32'h300);
   endtask

   task automatic test_reset_mid_refill();
      int lat, exp; logic [31:0] d, p; bit seen, any_v;
      wait_n = 0;
      @(posedge clk_i); #1; getir_istek_i = 1'b1; getir_ps_i = 32'h400;
      @(posedge clk_i); #1; getir_istek_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1; rst_i = 1'b0;
      @(posedge clk_i); #1; rst_i = 1'b1;
      @(negedge clk_i);
      checks++; if (ana_bellek_istek_o !== 1'b0 || ana_bellek_adres_o !== 32'd0) begin errors++; $display("FAIL rstmid_istek got %b/%h want 0/0", ana_bellek_istek_o, ana_bellek_adres_o); end
      any_v = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         if (getir_gecerli_o !== 1'b0) any_v = 1'b1;
      end
      checks++; if (any_v) begin errors++; $display("FAIL rstmid_noresp got valid pulse want none"); end
      mdl_flush();
      exp = mdl_lat(32'h400);
      fetch(32'h400, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != exp || d !== mem_word(32'h400)) begin errors++; $display("FAIL rstmid_miss400 got lat %0d data %h want lat %0d data %h", lat, d, exp, mem_word(32'h400)); end
      mdl_fill(32'h400);
      exp = mdl_lat(32'h10C);
      fetch(32'h10C, 0, 0, lat, d, p, seen);
      checks++; if (!seen || lat != exp || d !== 32'h44) begin errors++; $display("FAIL rstmid_miss10c got lat %0d data %h want lat %0d data 00000044", lat, d, exp); end
      mdl_fill(32'h10C);
   endtask

   task automatic test_random();
      int lat, exp; logic [31:0] d, p, pc; bit seen;
      for (int n = 0; n < 40; n++) begin
         wait_n = int'($urandom_range(0, 2));
         pc = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
            | (32'($urandom_range(0, 3)) << 2);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk_i); #1; temizle_i = 1'b1;
            @(posedge clk_i); #1; temizle_i = 1'b0;
            mdl_flush();
         end
         exp = mdl_lat(pc);
         fetch(pc, 0, 0, lat, d, p, seen);
         checks++;
         if (!seen || lat != exp || d !== mem_word(pc) || p !== pc) begin
            errors++;
            $display("FAIL rand%0d pc %h got lat %0d data %h ps %h want lat %0d data %h", n, pc, lat, d, p, exp, mem_word(pc));
         end
         mdl_fill(pc);
      end
      wait_n = 0;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_back_to_back();
      test_conflict();
      test_cancel_refill();
      test_flush();
      test_reset_mid_refill();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
